// File: rtl/boom_if.sv
// boom_if -- signal bundle between the game logic and the boom arbiter.
//
// Signals:
//   game_active      high while a round is running
//   req1 / req2      one-cycle fire-request pulses, player 1 / player 2
//   refill1/refill2  one-cycle ammo pickup pulses
//   cooldown         post-flight lockout length in clk cycles
//   ready_next_boom  pulse from the movement engine: all booms off-field
//   boom_active1/2   one-cycle launch pulses to the movement engine
//   busy             arbiter is not idle
//   owner            0 = player 1, 1 = player 2; current or last grant
//   ammo1 / ammo2    current ammo per player
//
// Modports:
//   master  drives the requests and observes the arbiter (game side)
//   slave   the arbiter itself
interface boom_if;
    logic        game_active;
    logic        req1;
    logic        req2;
    logic        refill1;
    logic        refill2;
    logic [24:0] cooldown;
    logic        ready_next_boom;
    logic        boom_active1;
    logic        boom_active2;
    logic        busy;
    logic        owner;
    logic [1:0]  ammo1;
    logic [1:0]  ammo2;

    modport master (
        output game_active, req1, req2, refill1, refill2, cooldown, ready_next_boom,
        input  boom_active1, boom_active2, busy, owner, ammo1, ammo2
    );

    modport slave (
        input  game_active, req1, req2, refill1, refill2, cooldown, ready_next_boom,
        output boom_active1, boom_active2, busy, owner, ammo1, ammo2
    );
endinterface

// File: rtl/boom_arbiter.sv
// boom_arbiter -- grants boom launches to two players, one boom at a time.
//
// A request is latched as pending when the player has ammo. An idle arbiter
// grants a pending player for one cycle (launch pulse), waits for the boom
// flight to end (engine pulse or timeout), then holds a cooldown lockout
// before accepting the next grant. Ties go to the player that did not own
// the previous grant.
//
// Ports:
//   clk   single clock, all state on posedge
//   rst   asynchronous, active-high reset
//   bus   boom_if.slave bundle (requests, refills, cooldown, engine pulse,
//         launch pulses, busy, owner, ammo counts)
//
// Parameters:
//   AMMO_MAX  booms held per player (1..3)
//   TIMEOUT   maximum flight cycles before forced release
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a pending request
// GRANT  | one-cycle launch pulse to the winner, ammo is consumed
// FLIGHT | boom in the air, counting toward TIMEOUT
// COOL   | post-flight lockout, lasts cooldown+1 cycles
module boom_arbiter #(
    parameter int AMMO_MAX = 3,
    parameter int TIMEOUT  = 2**26-1
) (
    input  logic  clk,
    input  logic  rst,
    boom_if.slave bus
);

    localparam logic [1:0]  AMMO_FULL    = AMMO_MAX[1:0];
    localparam logic [25:0] FLIGHT_LIMIT = TIMEOUT[25:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        FLIGHT = 2'd2,
        COOL   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [25:0] cnt_q, cnt_d;
    logic        pend1_q, pend1_d;
    logic        pend2_q, pend2_d;
    logic        owner_q, owner_d;
    logic [1:0]  ammo1_q, ammo1_d;
    logic [1:0]  ammo2_q, ammo2_d;
    logic        ga_q;

    logic        ga_rise;
    logic        grant1;
    logic        grant2;
    logic        inc1;
    logic        inc2;

    // Load on round start wins over everything; a simultaneous refill and
    // consume cancel out; increments saturate and decrements stop at zero.
    function automatic logic [1:0] next_ammo(
        input logic [1:0] cur,
        input logic       inc,
        input logic       dec,
        input logic       load
    );
        logic [1:0] res;
        res = cur;
        if (load) begin
            res = AMMO_FULL;
        end else if (inc && !dec) begin
            if (cur < AMMO_FULL) begin
                res = cur + 2'd1;
            end
        end else if (dec && !inc) begin
            if (cur != 2'd0) begin
                res = cur - 2'd1;
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend1_d = pend1_q;
        pend2_d = pend2_q;
        owner_d = owner_q;

        ga_rise = bus.game_active & ~ga_q;

        // The launch pulse is gated by game_active so a round that ends during
        // GRANT never launches or spends ammo.
        grant1 = (state_q == GRANT) & bus.game_active & ~owner_q;
        grant2 = (state_q == GRANT) & bus.game_active &  owner_q;

        // Ammo is frozen while no round is running.
        inc1 = bus.refill1 & bus.game_active;
        inc2 = bus.refill2 & bus.game_active;

        if (bus.game_active) begin
            if (bus.req1 && (ammo1_q != 2'd0)) begin
                pend1_d = 1'b1;
            end
            if (bus.req2 && (ammo2_q != 2'd0)) begin
                pend2_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (pend1_q || pend2_q) begin
                    state_d = GRANT;
                    // owner is updated on entry so it names the player being
                    // launched during GRANT.
                    if (pend1_q && pend2_q) begin
                        owner_d = ~owner_q;
                    end else begin
                        owner_d = pend2_q;
                    end
                end
            end
            GRANT: begin
                state_d = FLIGHT;
                cnt_d   = 26'd0;
                // Clearing after the set above: a fresh request from the
                // winner in its own grant cycle is dropped, which keeps a
                // pending flag from outliving the ammo that backed it.
                if (grant1) begin
                    pend1_d = 1'b0;
                end
                if (grant2) begin
                    pend2_d = 1'b0;
                end
            end
            FLIGHT: begin
                if (bus.ready_next_boom || (cnt_q == FLIGHT_LIMIT)) begin
                    state_d = COOL;
                    cnt_d   = 26'd0;
                end else begin
                    cnt_d = cnt_q + 26'd1;
                end
            end
            COOL: begin
                if (cnt_q == {1'b0, bus.cooldown}) begin
                    state_d = IDLE;
                    cnt_d   = 26'd0;
                end else begin
                    cnt_d = cnt_q + 26'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 26'd0;
            end
        endcase

        if (!bus.game_active) begin
            state_d = IDLE;
            cnt_d   = 26'd0;
            pend1_d = 1'b0;
            pend2_d = 1'b0;
        end

        ammo1_d = next_ammo(ammo1_q, inc1, grant1, ga_rise);
        ammo2_d = next_ammo(ammo2_q, inc2, grant2, ga_rise);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 26'd0;
            pend1_q <= 1'b0;
            pend2_q <= 1'b0;
            owner_q <= 1'b1;
            ammo1_q <= AMMO_FULL;
            ammo2_q <= AMMO_FULL;
            ga_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend1_q <= pend1_d;
            pend2_q <= pend2_d;
            owner_q <= owner_d;
            ammo1_q <= ammo1_d;
            ammo2_q <= ammo2_d;
            ga_q    <= bus.game_active;
        end
    end

    assign bus.boom_active1 = grant1;
    assign bus.boom_active2 = grant2;
    assign bus.busy         = (state_q != IDLE);
    assign bus.owner        = owner_q;
    assign bus.ammo1        = ammo1_q;
    assign bus.ammo2        = ammo2_q;

endmodule

// File: doc/boom_arbiter.md
BOOM_ARBITER -- requirements
Module: boom_arbiter

Interface
REQ-001 SHALL have parameter AMMO_MAX, default 3, maximum booms held per player (1..3).
REQ-002 SHALL have parameter TIMEOUT, default 2**26-1, maximum flight cycles before forced release.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port game_active  input  1  high while a round is running.
REQ-006 SHALL have port req1 / req2  input  1 each  one-cycle fire-request pulses, player 1 / player 2.
REQ-007 SHALL have port refill1 / refill2  input  1 each  one-cycle ammo pickup pulses.
REQ-008 SHALL have port cooldown  input  25  post-flight lockout length, in clk cycles.
REQ-009 SHALL have port ready_next_boom  input  1  one-cycle pulse from the boom movement engine: all booms off-field.
REQ-010 SHALL have port boom_active1 / boom_active2  output  1 each  one-cycle launch pulses to the movement engine.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port owner  output  1  0 = player 1, 1 = player 2; player of the current or last grant.
REQ-013 SHALL have port ammo1 / ammo2  output  2 each  current ammo per player.

Function
REQ-014 SHALL implement states IDLE, GRANT, FLIGHT, COOL.
REQ-015 SHALL set pending flag pendN on reqN when ammoN != 0 and game_active=1; a request with ammoN == 0 SHALL be dropped.
REQ-016 SHALL hold pending flags until granted; a repeated reqN while pendN=1 has no further effect.
REQ-017 IDLE: if any pending, SHALL go to GRANT next cycle; if only one is pending, that player wins; if both are pending, the player not equal to owner wins (round-robin).
REQ-018 GRANT: SHALL last exactly one cycle, assert boom_activeN=1 for the winner only, update owner, clear the winner's pendN, and decrement ammoN; then go to FLIGHT.
REQ-019 FLIGHT: SHALL count cycles from 0; on ready_next_boom=1, or when the count reaches TIMEOUT, SHALL go to COOL and clear the count.
REQ-020 COOL: SHALL count from 0 and return to IDLE in the cycle after count == cooldown, i.e. COOL lasts cooldown+1 cycles (cooldown=0 gives 1 cycle).
REQ-021 Requests SHALL be latched in every state; latency from a request in IDLE to boom_active is 2 cycles (pend set, then GRANT).
REQ-022 refillN SHALL increment ammoN, saturating at AMMO_MAX.
REQ-023 A refill and a decrement on the same player in the same cycle SHALL leave ammoN unchanged.
REQ-024 ready_next_boom outside FLIGHT SHALL be ignored.
REQ-025 Counters SHALL be 26 bits; the cooldown comparison SHALL be zero-extended.
REQ-026 game_active=0 SHALL force IDLE from any state at the next edge, clear both pending flags and both counters, and suppress boom_active; ammo is held.
REQ-027 On a 0->1 transition of game_active (registered edge detect), ammo1 and ammo2 SHALL load AMMO_MAX.
REQ-028 The outputs boom_active1 and boom_active2 SHALL never both be 1, and SHALL never be 1 outside GRANT.

Reset
REQ-029 While rst=1: state=IDLE, pending=0, counters=0, boom_active1/2=0, busy=0, owner=1 (so player 1 wins the first tie), ammo1=ammo2=AMMO_MAX, edge-detect register=0.
REQ-030 Reset asserted mid-FLIGHT or mid-COOL SHALL abort immediately with no further boom_active pulse after release.

Verification
REQ-031 game_active=1, cooldown=3, req1 pulse at cycle 0 -> boom_active1 at cycle 2, ammo1 3->2, busy=1; ready_next_boom at cycle 10 -> COOL cycles 11-14, busy=0 at cycle 15.
REQ-032 req1 and req2 in the same cycle from reset -> player 1 granted first; after cooldown player 2 granted; on the next simultaneous pair player 1 wins again.
REQ-033 Three grants to player 1 (ammo1=0), then req1 -> no pend, no pulse; refill1 -> ammo1=1; req1 -> granted.
REQ-034 ammo2=3 with refill2 pulse -> ammo2 stays 3; refill2 in the GRANT cycle of player 2 with ammo2=2 -> ammo2 stays 2.
REQ-035 TIMEOUT=20, no ready_next_boom -> FLIGHT exits after 21 cycles to COOL; a stray ready_next_boom in IDLE -> no state change.
REQ-036 game_active dropped during FLIGHT with req2 pending -> IDLE next cycle, pend2 cleared, no boom_active2; game_active raised again -> ammo1=ammo2=3.
